// File: rtl/pid_controller_mc.sv
// Time-multiplexed multi-channel PID controller: one shared multiplier walks every
// channel through P, I (anti-windup clamped) and D terms on each sample tick.
module pid_controller_mc #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned DATA_WIDTH   = 9,
  parameter int unsigned K_INT_WIDTH  = 8,
  parameter int unsigned K_FRAC_WIDTH = 8,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned INT_LIMIT    = 1000,
  parameter int unsigned DIVISOR      = 1249999
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic                                          clear_int,
  input  logic [NUM_CH*(K_INT_WIDTH+K_FRAC_WIDTH)-1:0] k_p,
  input  logic [NUM_CH*(K_INT_WIDTH+K_FRAC_WIDTH)-1:0] k_i,
  input  logic [NUM_CH*(K_INT_WIDTH+K_FRAC_WIDTH)-1:0] k_d,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                  setpoint,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                  feedback,
  output logic [NUM_CH*OUT_WIDTH-1:0]                   control_signal,
  output logic                                          out_valid,
  output logic                                          busy,
  output logic [NUM_CH-1:0]                             sat,
  output logic                                          overrun
);

  localparam int unsigned KW = K_INT_WIDTH + K_FRAC_WIDTH;
  localparam int unsigned EW = DATA_WIDTH + 1;
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TW = $clog2(DIVISOR + 1);
  // Internal width covers the widest product (gain x error delta) and the integral clamp.
  localparam int unsigned MW = KW + EW + 3;
  localparam int unsigned LW = $clog2(INT_LIMIT + 1) + K_FRAC_WIDTH + 2;
  localparam int unsigned WW = (LW > MW) ? LW : MW;

  localparam logic signed [WW-1:0] AccMax = WW'(INT_LIMIT) << K_FRAC_WIDTH;
  localparam logic signed [WW-1:0] AccMin = -AccMax;
  localparam logic signed [WW-1:0] OutMax = WW'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [WW-1:0] OutMin = -OutMax - WW'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StMulP, StMulI, StMulD, StSum, StDone} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           cnt_q;
  logic [CW-1:0]           ch_q;
  logic signed [EW-1:0]    err_q;
  logic signed [KW-1:0]    kp_q, ki_q, kd_q;
  logic signed [WW-1:0]    p_q, d_q;
  logic signed [WW-1:0]    acc_q    [NUM_CH];
  logic signed [EW-1:0]    prev_q   [NUM_CH];
  logic signed [OUT_WIDTH-1:0] shadow_q [NUM_CH];
  logic [NUM_CH-1:0]       sat_sh_q, sat_q;
  logic [NUM_CH*OUT_WIDTH-1:0] cs_q;
  logic                    overrun_q;

  logic                    tick, last_ch;
  logic [DATA_WIDTH-1:0]   sp_ch, fb_ch;
  logic signed [EW-1:0]    err_ld, prev_cur;
  logic signed [EW:0]      diff, mul_b;
  logic signed [KW-1:0]    mul_a;
  logic signed [WW-1:0]    prod, acc_cur, acc_sum, acc_new, sum_full, sum_sh;
  logic signed [OUT_WIDTH-1:0] s_sat;
  logic                    clipped;

  assign tick    = (cnt_q == TW'(DIVISOR));
  assign last_ch = (ch_q == CW'(NUM_CH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (tick && enable && !clear_int) state_d = StLoad;
      StLoad:  state_d = StMulP;
      StMulP:  state_d = StMulI;
      StMulI:  state_d = StMulD;
      StMulD:  state_d = StSum;
      StSum:   state_d = last_ch ? StDone : StLoad;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sp_ch    = setpoint[ch_q*DATA_WIDTH +: DATA_WIDTH];
    fb_ch    = feedback[ch_q*DATA_WIDTH +: DATA_WIDTH];
    err_ld   = $signed({1'b0, sp_ch}) - $signed({1'b0, fb_ch});
    prev_cur = prev_q[ch_q];
    acc_cur  = acc_q[ch_q];
    diff     = (EW+1)'(err_q) - (EW+1)'(prev_cur);

    mul_a = kp_q;
    mul_b = (EW+1)'(err_q);
    case (state_q)
      StMulI:  mul_a = ki_q;
      StMulD: begin
        mul_a = kd_q;
        mul_b = diff;
      end
      default: mul_a = kp_q;
    endcase
    prod = WW'(mul_a) * WW'(mul_b);

    acc_sum = acc_cur + prod;
    if (acc_sum > AccMax)      acc_new = AccMax;
    else if (acc_sum < AccMin) acc_new = AccMin;
    else                       acc_new = acc_sum;

    sum_full = p_q + acc_cur + d_q;
    sum_sh   = sum_full >>> K_FRAC_WIDTH;
    clipped  = (sum_sh > OutMax) || (sum_sh < OutMin);
    if (sum_sh > OutMax)      s_sat = OutMax[OUT_WIDTH-1:0];
    else if (sum_sh < OutMin) s_sat = OutMin[OUT_WIDTH-1:0];
    else                      s_sat = sum_sh[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      ch_q      <= '0;
      err_q     <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      p_q       <= '0;
      d_q       <= '0;
      cs_q      <= '0;
      sat_q     <= '0;
      sat_sh_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]    <= '0;
        prev_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick && state_q != StIdle) overrun_q <= 1'b1;
      case (state_q)
        StIdle: begin
          // Clear takes priority over a coincident tick; the FSM also refuses to start.
          if (clear_int) begin
            for (int i = 0; i < NUM_CH; i++) begin
              acc_q[i]  <= '0;
              prev_q[i] <= '0;
            end
          end else if (tick && enable) begin
            ch_q <= '0;
          end
        end
        StLoad: begin
          err_q <= err_ld;
          kp_q  <= k_p[ch_q*KW +: KW];
          ki_q  <= k_i[ch_q*KW +: KW];
          kd_q  <= k_d[ch_q*KW +: KW];
        end
        StMulP: p_q <= prod;
        StMulI: acc_q[ch_q] <= acc_new;
        StMulD: begin
          d_q          <= prod;
          prev_q[ch_q] <= err_q;
        end
        StSum: begin
          shadow_q[ch_q] <= s_sat;
          sat_sh_q[ch_q] <= clipped;
          // Publish on the last channel so outputs are already new during DONE.
          if (last_ch) begin
            for (int i = 0; i < NUM_CH; i++) begin
              cs_q[i*OUT_WIDTH +: OUT_WIDTH] <= (i == int'(ch_q)) ? s_sat : shadow_q[i];
              sat_q[i] <= (i == int'(ch_q)) ? clipped : sat_sh_q[i];
            end
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign control_signal = cs_q;
  assign sat            = sat_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != StIdle);
  assign out_valid      = (state_q == StDone);

endmodule

// File: tb/tb_pid_controller_mc.sv
// Directed bench for pid_controller_mc: expected frames go into a scoreboard queue and
// a monitor compares them whenever out_valid fires.
module tb_pid_controller_mc;

  localparam int NC = 2;
  localparam int DW = 9;
  localparam int KW = 16;
  localparam int OW = 16;

  typedef struct {
    int c0;
    int c1;
    int s;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic clear_int = 1'b0;
  logic [NC*KW-1:0] k_p = '0, k_i = '0, k_d = '0;
  logic [NC*DW-1:0] setpoint = '0, feedback = '0;

  logic [NC*OW-1:0] cs, f_cs;
  logic             out_valid, busy, overrun, f_valid, f_busy, f_overrun;
  logic [NC-1:0]    sat, f_sat;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   nvalid = 0;
  bit   fast_done = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  pid_controller_mc #(
    .NUM_CH(2), .DATA_WIDTH(9), .K_INT_WIDTH(8), .K_FRAC_WIDTH(8), .OUT_WIDTH(16),
    .INT_LIMIT(12), .DIVISOR(15)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_int(clear_int),
    .k_p(k_p), .k_i(k_i), .k_d(k_d), .setpoint(setpoint), .feedback(feedback),
    .control_signal(cs), .out_valid(out_valid), .busy(busy), .sat(sat), .overrun(overrun)
  );

  // Tick period 6 is shorter than the 11-cycle frame, so every other tick overruns.
  pid_controller_mc #(
    .NUM_CH(2), .DATA_WIDTH(9), .K_INT_WIDTH(8), .K_FRAC_WIDTH(8), .OUT_WIDTH(16),
    .INT_LIMIT(12), .DIVISOR(5)
  ) u_fast (
    .clk(clk), .reset(reset), .enable(enable), .clear_int(clear_int),
    .k_p(k_p), .k_i(k_i), .k_d(k_d), .setpoint(setpoint), .feedback(feedback),
    .control_signal(f_cs), .out_valid(f_valid), .busy(f_busy), .sat(f_sat),
    .overrun(f_overrun)
  );

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic set_ch(input int ch, input int kp, input int ki, input int kd,
                        input int sp, input int fb);
    k_p[ch*KW +: KW]      = kp[KW-1:0];
    k_i[ch*KW +: KW]      = ki[KW-1:0];
    k_d[ch*KW +: KW]      = kd[KW-1:0];
    setpoint[ch*DW +: DW] = sp[DW-1:0];
    feedback[ch*DW +: DW] = fb[DW-1:0];
  endtask

  task automatic wait_valid(output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && !reset) && n < 60);
    if (n >= 60) check("valid_timeout", n, 0);
    at = cyc;
  endtask

  task automatic expect_frame(input int c0, input int c1, input int s, output int at);
    exp_t e;
    e.c0 = c0;
    e.c1 = c1;
    e.s  = s;
    sb.push_back(e);
    wait_valid(at);
  endtask

  // Called from the DONE cycle: the following cycle is IDLE, where clear is honoured.
  task automatic pulse_clear();
    @(negedge clk);
    clear_int = 1'b1;
    @(negedge clk);
    clear_int = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        nvalid++;
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("ch0_out", int'($signed(cs[OW-1:0])), e.c0);
          check("ch1_out", int'($signed(cs[2*OW-1:OW])), e.c1);
          check("sat", int'(sat), e.s);
        end
      end
    end
  end

  initial begin : fast_check
    int t[3];
    int n;
    wait (reset == 1'b0);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!f_valid && n < 40);
      if (n >= 40) check("fast_timeout", n, 0);
      t[k] = cyc;
    end
    check("fast_first_valid", t[0], 16);
    check("fast_interval0", t[1] - t[0], 12);
    check("fast_interval1", t[2] - t[1], 12);
    check("fast_overrun", int'(f_overrun), 1);
    fast_done = 1'b1;
  end

  initial begin : stimulus
    int at;
    int nv;
    set_ch(0, 'h0200, 0, 0, 100, 90);
    set_ch(1, 'h0100, 0, 0, 50, 60);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", int'(cs), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_overrun", int'(overrun), 0);

    // P only; tick at cycle 15 after release, DONE 11 cycles later.
    begin
      exp_t e;
      e.c0 = 20; e.c1 = -10; e.s = 0;
      sb.push_back(e);
    end
    reset = 1'b0;
    wait_valid(at);
    check("p_latency", at, 26);

    // Integral with anti-windup at 12.
    set_ch(0, 0, 'h0080, 0, 100, 90);
    set_ch(1, 0, 0, 0, 0, 0);
    expect_frame(5, 0, 0, at);
    expect_frame(10, 0, 0, at);
    expect_frame(12, 0, 0, at);
    expect_frame(12, 0, 0, at);
    pulse_clear();
    expect_frame(5, 0, 0, at);

    // Derivative from a freshly cleared prev_error.
    pulse_clear();
    set_ch(0, 0, 0, 'h0100, 100, 90);
    expect_frame(10, 0, 0, at);
    expect_frame(0, 0, 0, at);
    set_ch(0, 0, 0, 'h0100, 100, 96);
    expect_frame(-6, 0, 0, at);

    // Saturation both ways.
    set_ch(0, 'h7F00, 0, 0, 511, 0);
    expect_frame(32767, 0, 1, at);
    set_ch(0, 'h7F00, 0, 0, 0, 511);
    expect_frame(-32768, 0, 1, at);

    // Disabled: three periods without frames, outputs held.
    enable = 1'b0;
    nv = nvalid;
    repeat (48) @(negedge clk);
    check("disabled_no_valid", nvalid, nv);
    check("held_ch0", int'($signed(cs[OW-1:0])), -32768);
    check("held_sat", int'(sat), 1);
    check("disabled_busy", int'(busy), 0);
    set_ch(0, 'h7F00, 0, 0, 0, 0);
    enable = 1'b1;
    expect_frame(0, 0, 0, at);
    check("main_overrun", int'(overrun), 0);

    // Reset mid-frame while the integrator is non-zero.
    set_ch(0, 0, 'h0080, 0, 100, 90);
    expect_frame(5, 0, 0, at);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!busy && n < 40);
      if (n >= 40) check("busy_timeout", n, 0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_cs", int'(cs), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_sat", int'(sat), 0);
    repeat (2) @(negedge clk);
    begin
      exp_t e;
      e.c0 = 5; e.c1 = 0; e.s = 0;
      sb.push_back(e);
    end
    reset = 1'b0;
    wait_valid(at);
    check("post_rst_latency", at, 26);

    check("sb_drained", sb.size(), 0);
    check("fast_done", int'(fast_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
